// File: rtl/dco_pkg.sv
// dco_pkg: shared defaults, dither LFSR constants and the increment clamp for dco_gen
//   ACC_W/CTRL_W      accumulator and correction widths
//   CENTER_INC        nominal increment (4096 -> 16-cycle period at ACC_W=16)
//   INC_MIN/INC_MAX   bounds on the applied increment
//   LFSR_SEED/TAPS    dither LFSR reset value and Fibonacci taps 16,14,13,11
package dco_pkg;
  localparam int ACC_W = 16;
  localparam int CTRL_W = 14;
  localparam int CENTER_INC = 4096;
  localparam int INC_MIN = 1024;
  localparam int INC_MAX = 8192;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic int clamp_inc(input int v, input int lo, input int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
endpackage

// File: rtl/dco_lfsr.sv
// dco_lfsr: 16-bit Fibonacci LFSR dither source, built only with DCO_DITHER_EN defined
//   clk      system clock
//   reset    synchronous active-low reset, reloads LFSR_SEED
//   dither_o two low LFSR bits added to the accumulator increment
`ifdef DCO_DITHER_EN
module dco_lfsr import dco_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] dither_o
);
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  always_ff @(posedge clk) lfsr_q <= !reset ? LFSR_SEED : lfsr_d;
  assign dither_o = lfsr_q[1:0];
endmodule
`endif

// File: rtl/dco_gen.sv
// dco_gen: phase-accumulator DCO for the DPLL, corrections applied only at accumulator wrap
//   clk        system clock
//   reset      synchronous active-low reset
//   ctrlIn     signed correction relative to CENTER_INC
//   ctrlValid  ctrlIn valid; transfer when ctrlValid && ctrlReady
//   ctrlReady  high when no correction is pending
//   sigOut     registered accumulator MSB, sigOut_n its complement
//   wrapPulse  one-cycle pulse on accumulator carry-out
//   incOut     increment currently applied (excludes dither)
// Optional: DCO_DITHER_EN adds lfsr[1:0] from dco_lfsr to the addend.
module dco_gen import dco_pkg::*; #(
  parameter int ACC_W = dco_pkg::ACC_W,
  parameter int CTRL_W = dco_pkg::CTRL_W,
  parameter int CENTER_INC = dco_pkg::CENTER_INC,
  parameter int INC_MIN = dco_pkg::INC_MIN,
  parameter int INC_MAX = dco_pkg::INC_MAX
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [CTRL_W-1:0] ctrlIn,
  input  logic                     ctrlValid,
  output logic                     ctrlReady,
  output logic                     sigOut,
  output logic                     sigOut_n,
  output logic                     wrapPulse,
  output logic [ACC_W-1:0]         incOut
);
  logic [ACC_W-1:0] acc_q, acc_d, inc_q, inc_d, pend_inc_q, pend_inc_d, addend;
  logic pend_q, pend_d, sig_q, wrap_q, xfer, apply;
  logic [ACC_W:0] sum;
  logic signed [ACC_W+1:0] req;
`ifdef DCO_DITHER_EN
  logic [1:0] dither;
  dco_lfsr u_lfsr (.clk(clk), .reset(reset), .dither_o(dither));
  assign addend = inc_q + ACC_W'(dither);
`else
  assign addend = inc_q;
`endif
  // apply and transfer are mutually exclusive: apply needs a pending value, transfer needs none
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, addend};
    req = (ACC_W+2)'(CENTER_INC) + (ACC_W+2)'(ctrlIn);
    xfer = ctrlValid && !pend_q;
    apply = sum[ACC_W] && pend_q;
    acc_d = sum[ACC_W-1:0];
    inc_d = apply ? pend_inc_q : inc_q;
    pend_d = apply ? 1'b0 : xfer ? 1'b1 : pend_q;
    pend_inc_d = xfer ? ACC_W'(clamp_inc(int'(req), INC_MIN, INC_MAX)) : pend_inc_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
      inc_q <= ACC_W'(CENTER_INC);
      pend_q <= 1'b0;
      pend_inc_q <= '0;
      sig_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      inc_q <= inc_d;
      pend_q <= pend_d;
      pend_inc_q <= pend_inc_d;
      sig_q <= sum[ACC_W-1];
      wrap_q <= sum[ACC_W];
    end
  end
  assign ctrlReady = !pend_q;
  assign sigOut = sig_q;
  assign sigOut_n = ~sig_q;
  assign wrapPulse = wrap_q;
  assign incOut = inc_q;
endmodule

// File: tb/tb_dco_gen.sv
// tb_dco_gen: directed self-checking bench for dco_gen
module tb_dco_gen;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [13:0] ctrlIn = '0;
  logic ctrlValid = 1'b0;
  logic ctrlReady, sigOut, sigOut_n, wrapPulse;
  logic [15:0] incOut;
  int total = 0;
  int bad = 0;

  dco_gen dut (
    .clk(clk), .reset(reset), .ctrlIn(ctrlIn), .ctrlValid(ctrlValid),
    .ctrlReady(ctrlReady), .sigOut(sigOut), .sigOut_n(sigOut_n),
    .wrapPulse(wrapPulse), .incOut(incOut)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0;
    ctrlValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({sigOut, sigOut_n, wrapPulse, ctrlReady} !== 4'b0101) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0101", {sigOut, sigOut_n, wrapPulse, ctrlReady});
    end
    total++;
    if (incOut !== 16'd4096) begin
      bad++;
      $display("FAIL reset_inc got=%0d want=4096", incOut);
    end
    reset = 1'b1;
  endtask

  // starts at a negedge where acc=0 and inc=4096
  task automatic test_free_run();
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      total++;
      if ({wrapPulse, sigOut, sigOut_n} !== {k % 16 == 0, k % 16 >= 8, k % 16 < 8} || incOut !== 16'd4096) begin
        bad++;
        $display("FAIL free_k%0d got=%b/%0d want=%b/4096", k, {wrapPulse, sigOut, sigOut_n}, incOut,
                 {k % 16 == 0, k % 16 >= 8, k % 16 < 8});
      end
    end
  endtask

  task automatic test_fast();
    repeat (4) @(negedge clk);
    ctrlIn = 14'sd4096;
    ctrlValid = 1'b1;
    @(negedge clk);
    ctrlValid = 1'b0;
    total++;
    if (ctrlReady !== 1'b0) begin
      bad++;
      $display("FAIL fast_pending got=%b want=0", ctrlReady);
    end
    for (int e = 38; e <= 47; e++) begin
      @(negedge clk);
      total++;
      if ({ctrlReady, wrapPulse} !== 2'b00 || incOut !== 16'd4096) begin
        bad++;
        $display("FAIL fast_wait_e%0d got=%b/%0d want=00/4096", e, {ctrlReady, wrapPulse}, incOut);
      end
    end
    @(negedge clk);
    total++;
    if ({wrapPulse, ctrlReady} !== 2'b11 || incOut !== 16'd8192) begin
      bad++;
      $display("FAIL fast_apply got=%b/%0d want=11/8192", {wrapPulse, ctrlReady}, incOut);
    end
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      total++;
      if ({wrapPulse, sigOut} !== {j % 8 == 0, j % 8 >= 4}) begin
        bad++;
        $display("FAIL fast_period_j%0d got=%b want=%b", j, {wrapPulse, sigOut}, {j % 8 == 0, j % 8 >= 4});
      end
    end
  endtask

  task automatic test_clamp_low();
    ctrlIn = -14'sd8000;
    ctrlValid = 1'b1;
    @(negedge clk);
    ctrlValid = 1'b0;
    total++;
    if (ctrlReady !== 1'b0 || incOut !== 16'd8192) begin
      bad++;
      $display("FAIL low_pending got=%b/%0d want=0/8192", ctrlReady, incOut);
    end
    repeat (6) @(negedge clk);
    @(negedge clk);
    total++;
    if ({wrapPulse, ctrlReady} !== 2'b11 || incOut !== 16'd1024) begin
      bad++;
      $display("FAIL low_apply got=%b/%0d want=11/1024", {wrapPulse, ctrlReady}, incOut);
    end
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk);
      total++;
      if ({wrapPulse, sigOut} !== {j % 64 == 0, j % 64 >= 32}) begin
        bad++;
        $display("FAIL low_period_j%0d got=%b want=%b", j, {wrapPulse, sigOut}, {j % 64 == 0, j % 64 >= 32});
      end
    end
  endtask

  task automatic test_clamp_high_held();
    logic err;
    ctrlIn = 14'sd7000;
    ctrlValid = 1'b1;
    @(negedge clk);
    ctrlIn = -14'sd2000;
    total++;
    if (ctrlReady !== 1'b0) begin
      bad++;
      $display("FAIL high_pending got=%b want=0", ctrlReady);
    end
    err = 1'b0;
    for (int e = 2; e <= 63; e++) begin
      @(negedge clk);
      if (ctrlReady !== 1'b0 || wrapPulse !== 1'b0 || incOut !== 16'd1024) err = 1'b1;
    end
    total++;
    if (err) begin
      bad++;
      $display("FAIL high_hold got=1 want=0 (ready/wrap/inc changed while pending)");
    end
    @(negedge clk);
    total++;
    if ({wrapPulse, ctrlReady} !== 2'b11 || incOut !== 16'd8192) begin
      bad++;
      $display("FAIL high_apply got=%b/%0d want=11/8192", {wrapPulse, ctrlReady}, incOut);
    end
    @(negedge clk);
    ctrlValid = 1'b0;
    total++;
    if (ctrlReady !== 1'b0 || incOut !== 16'd8192) begin
      bad++;
      $display("FAIL second_accept got=%b/%0d want=0/8192", ctrlReady, incOut);
    end
    repeat (6) @(negedge clk);
    @(negedge clk);
    total++;
    if ({wrapPulse, ctrlReady} !== 2'b11 || incOut !== 16'd2096) begin
      bad++;
      $display("FAIL second_apply got=%b/%0d want=11/2096", {wrapPulse, ctrlReady}, incOut);
    end
  endtask

  task automatic test_reset_mid();
    ctrlIn = 14'sd100;
    ctrlValid = 1'b1;
    @(negedge clk);
    ctrlValid = 1'b0;
    total++;
    if (ctrlReady !== 1'b0) begin
      bad++;
      $display("FAIL mid_pending got=%b want=0", ctrlReady);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({sigOut, sigOut_n, wrapPulse, ctrlReady} !== 4'b0101 || incOut !== 16'd4096) begin
      bad++;
      $display("FAIL mid_reset got=%b/%0d want=0101/4096", {sigOut, sigOut_n, wrapPulse, ctrlReady}, incOut);
    end
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      total++;
      if ({wrapPulse, sigOut, ctrlReady} !== {k == 16, k >= 8 && k < 16, 1'b1} || incOut !== 16'd4096) begin
        bad++;
        $display("FAIL mid_restart_k%0d got=%b/%0d want=%b/4096", k, {wrapPulse, sigOut, ctrlReady}, incOut,
                 {k == 16, k >= 8 && k < 16, 1'b1});
      end
    end
  endtask

`ifdef DCO_DITHER_EN
  task automatic test_dither();
    int first, last, prev, n, pmin, pmax;
    first = -1; last = -1; prev = -1; n = 0; pmin = 1000; pmax = 0;
    for (int c = 1; c <= 1024; c++) begin
      @(negedge clk);
      if (wrapPulse === 1'b1) begin
        if (first < 0) first = c;
        if (prev >= 0) begin
          pmin = (c - prev) < pmin ? (c - prev) : pmin;
          pmax = (c - prev) > pmax ? (c - prev) : pmax;
        end
        prev = c;
        last = c;
        n++;
      end
    end
    total++;
    if (n < 2 || (last - first) * 1000 < 15990 * (n - 1) || (last - first) * 1000 > 16010 * (n - 1)) begin
      bad++;
      $display("FAIL dither_avg got=%0d/%0d want=15.99..16.01", last - first, n - 1);
    end
    total++;
    if (pmin == pmax) begin
      bad++;
      $display("FAIL dither_spread got=%0d..%0d want=unequal", pmin, pmax);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DCO_DITHER_EN
    test_dither();
`else
    test_free_run();
    test_fast();
    test_clamp_low();
    test_clamp_high_held();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
